// File: rtl/can_crc_pkg.sv
// can_crc_pkg: shared types, widths and helpers for the CAN CRC engine.
// Contents: crc_mode_e, crc_state_e, CRC widths, crc_width() and gray3().
package can_crc_pkg;

    typedef enum logic [1:0] {
        CRC15 = 2'd0,
        CRC17 = 2'd1,
        CRC21 = 2'd2
    } crc_mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StCheck
    } crc_state_e;

    localparam int unsigned CRC15_W = 15;
    localparam int unsigned CRC17_W = 17;
    localparam int unsigned CRC21_W = 21;

    // Number of CRC bits in the check phase for the latched mode.
    function automatic logic [4:0] crc_width(input crc_mode_e m);
        unique case (m)
            CRC15:   return 5'(CRC15_W);
            CRC17:   return 5'(CRC17_W);
            default: return 5'(CRC21_W);
        endcase
    endfunction

    // Binary to reflected Gray code.
    function automatic logic [2:0] gray3(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/can_crc_if.sv
// can_crc_if: bit-stream and result signals between the receive FSM / destuffer
// (master) and the CRC engine (slave).
//   start, mode, fd_iso, calc_end, abort : frame control from the receive FSM
//   bit_valid, bit_in, stuff_bit         : destuffed bit stream
//   crc_15/17/21, busy, crc_valid, crc_ok, stuff_cnt, stuff_par : results
interface can_crc_if;
    logic        start;
    logic [1:0]  mode;
    logic        fd_iso;
    logic        bit_valid;
    logic        bit_in;
    logic        stuff_bit;
    logic        calc_end;
    logic        abort;
    logic [14:0] crc_15;
    logic [16:0] crc_17;
    logic [20:0] crc_21;
    logic        busy;
    logic        crc_valid;
    logic        crc_ok;
    logic [2:0]  stuff_cnt;
    logic        stuff_par;

    modport master (
        output start, mode, fd_iso, bit_valid, bit_in, stuff_bit, calc_end, abort,
        input  crc_15, crc_17, crc_21, busy, crc_valid, crc_ok, stuff_cnt, stuff_par
    );

    modport slave (
        input  start, mode, fd_iso, bit_valid, bit_in, stuff_bit, calc_end, abort,
        output crc_15, crc_17, crc_21, busy, crc_valid, crc_ok, stuff_cnt, stuff_par
    );
endinterface

// File: rtl/can_crc_lfsr.sv
// can_crc_lfsr: one serial CRC register (MSB-first, Galois form).
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   load         loads init_val (wins over en)
//   init_val     start-of-frame value
//   en, stuff    bit qualifier and stuff marker; stuff bits are dropped when SkipStuff
//   din          serial data bit
//   crc          current register value
//   crc_nxt      value the register takes if din is accepted this cycle
module can_crc_lfsr #(
    parameter int unsigned       Width     = 15,
    parameter logic [Width-1:0]  Poly      = '0,
    parameter bit                SkipStuff = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] init_val,
    input  logic             en,
    input  logic             stuff,
    input  logic             din,
    output logic [Width-1:0] crc,
    output logic [Width-1:0] crc_nxt
);

    logic [Width-1:0] crc_q;
    logic             fb;
    logic             upd;

    always_comb begin
        fb      = din ^ crc_q[Width-1];
        crc_nxt = {crc_q[Width-2:0], 1'b0} ^ (fb ? Poly : '0);
        upd     = en & ~(SkipStuff & stuff);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_q <= '0;
        end else if (load) begin
            crc_q <= init_val;
        end else if (upd) begin
            crc_q <= crc_nxt;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/can_crc_unit.sv
// can_crc_unit: CRC-15/17/21 engine for the CAN / CAN FD receive path.
// All three CRCs run in parallel over the data field (CALC); afterwards the
// received CRC is shifted through the selected register (CHECK) and a zero
// residue sets crc_ok.
// Ports: clk, rst (async, active-low) and bus (can_crc_if.slave).
// Optional: define CAN_CRC_STUFF_CNT_EN to build the Gray-coded stuff counter;
// otherwise stuff_cnt and stuff_par read 0.
import can_crc_pkg::*;

module can_crc_unit #(
    parameter logic [15:0] CRC15_POL = 16'hC599,
    parameter logic [19:0] CRC17_POL = 20'h3685B,
    parameter logic [23:0] CRC21_POL = 24'h302899
) (
    input  logic   clk,
    input  logic   rst,
    can_crc_if.slave bus
);

    crc_state_e  state_q;
    crc_mode_e   mode_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic        valid_q;
    logic        ok_q;

    logic        load;
    logic        calc_bit;
    logic        check_bit;
    logic        en15, en17, en21;
    logic        sel_zero;
    logic [4:0]  width_sel;
    logic [14:0] c15, n15;
    logic [16:0] c17, n17;
    logic [20:0] c21, n21;

    always_comb begin
        load      = bus.start & ~bus.abort;
        calc_bit  = bus.bit_valid & ~bus.abort & (state_q == StCalc);
        // Fixed stuff bits in the CRC field are invisible to the check.
        check_bit = bus.bit_valid & ~bus.abort & ~bus.stuff_bit & (state_q == StCheck);
        en15      = calc_bit | (check_bit & (mode_q == CRC15));
        en17      = calc_bit | (check_bit & (mode_q == CRC17));
        en21      = calc_bit | (check_bit & (mode_q == CRC21));
        width_sel = crc_width(mode_q);
        // Residue of the register after the bit being accepted now.
        sel_zero  = 1'b0;
        unique case (mode_q)
            CRC15:   sel_zero = (n15 == '0);
            CRC17:   sel_zero = (n17 == '0);
            default: sel_zero = (n21 == '0);
        endcase
    end

    can_crc_lfsr #(.Width(CRC15_W), .Poly(CRC15_POL[14:0]), .SkipStuff(1'b1)) u_crc15 (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .init_val (15'h0),
        .en       (en15),
        .stuff    (bus.stuff_bit),
        .din      (bus.bit_in),
        .crc      (c15),
        .crc_nxt  (n15)
    );

    can_crc_lfsr #(.Width(CRC17_W), .Poly(CRC17_POL[16:0]), .SkipStuff(1'b0)) u_crc17 (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .init_val (bus.fd_iso ? 17'h10000 : 17'h0),
        .en       (en17),
        .stuff    (bus.stuff_bit),
        .din      (bus.bit_in),
        .crc      (c17),
        .crc_nxt  (n17)
    );

    can_crc_lfsr #(.Width(CRC21_W), .Poly(CRC21_POL[20:0]), .SkipStuff(1'b0)) u_crc21 (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .init_val (bus.fd_iso ? 21'h100000 : 21'h0),
        .en       (en21),
        .stuff    (bus.stuff_bit),
        .din      (bus.bit_in),
        .crc      (c21),
        .crc_nxt  (n21)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            mode_q  <= CRC15;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.abort) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
            end else if (bus.start) begin
                state_q <= StCalc;
                busy_q  <= 1'b1;
                cnt_q   <= '0;
                ok_q    <= 1'b0;
                mode_q  <= (bus.mode == 2'd3) ? CRC21 : crc_mode_e'(bus.mode);
            end else begin
                unique case (state_q)
                    StCalc: begin
                        if (bus.calc_end) state_q <= StCheck;
                    end
                    StCheck: begin
                        if (check_bit) begin
                            if (cnt_q == width_sel - 5'd1) begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                                valid_q <= 1'b1;
                                ok_q    <= sel_zero;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 5'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.crc_15    = c15;
    assign bus.crc_17    = c17;
    assign bus.crc_21    = c21;
    assign bus.busy      = busy_q;
    assign bus.crc_valid = valid_q;
    assign bus.crc_ok    = ok_q;

`ifdef CAN_CRC_STUFF_CNT_EN
    logic [2:0] scnt_q, scnt_d;
    logic [2:0] sgray_q;
    logic       spar_q;

    always_comb begin
        scnt_d = scnt_q;
        if (bus.abort || bus.start) begin
            scnt_d = '0;
        end else if (state_q == StCalc && bus.bit_valid && bus.stuff_bit) begin
            scnt_d = scnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scnt_q  <= '0;
            sgray_q <= '0;
            spar_q  <= 1'b0;
        end else begin
            scnt_q  <= scnt_d;
            sgray_q <= gray3(scnt_d);
            spar_q  <= ^gray3(scnt_d);
        end
    end

    assign bus.stuff_cnt = sgray_q;
    assign bus.stuff_par = spar_q;
`else
    assign bus.stuff_cnt = 3'b000;
    assign bus.stuff_par = 1'b0;
`endif

endmodule

// File: doc/can_crc_unit.md
# can_crc_unit

Multi-mode CRC engine for the CAN / CAN FD receive path. It computes CRC-15 (Classical CAN), CRC-17 and CRC-21 (CAN FD) in parallel over the destuffed bit stream. After the data field it runs a check phase: the received CRC bits are shifted through the selected register, and the unit flags pass or fail on a zero residue. It sits between the bit destuffer and the receive FSM. Only the receive FSM controls the frame start, the end of the data field and aborts.

## Interface
Parameters:
- CRC15_POL, 16'hC599, CRC-15 generator; only bits [14:0] are used.
- CRC17_POL, 20'h3685B, CRC-17 generator; only bits [16:0] are used.
- CRC21_POL, 24'h302899, CRC-21 generator; only bits [20:0] are used.

Ports:
- clk  in  1  sampling clock.
- rst  in  1  reset. Asynchronous and active-low: 0 resets, 1 runs.
- start  in  1  one-cycle pulse that initialises all registers and enters CALC.
- mode  in  2  CRC select, latched on start: 0 = CRC-15, 1 = CRC-17, 2 = CRC-21. Value 3 is treated as 2.
- fd_iso  in  1  selects ISO init values; latched on start.
- bit_valid  in  1  qualifies bit_in and stuff_bit.
- bit_in  in  1  received bit.
- stuff_bit  in  1  marks the current bit as a stuff bit.
- calc_end  in  1  pulse marking the last data-field bit; enters CHECK.
- abort  in  1  error frame; returns to IDLE.
- crc_15  out  15  running CRC-15.
- crc_17  out  17  running CRC-17.
- crc_21  out  21  running CRC-21.
- busy  out  1  high in CALC or CHECK.
- crc_valid  out  1  one-cycle pulse: check complete.
- crc_ok  out  1  result of the check; held until the next start.
- stuff_cnt  out  3  Gray-coded stuff count, mod 8 (macro-dependent, see Configuration).
- stuff_par  out  1  parity of stuff_cnt (macro-dependent, see Configuration).

## Operation
FSM states: IDLE, CALC, CHECK.
- IDLE -> CALC on start.
- CALC -> CHECK on calc_end.
- CHECK -> IDLE after W non-stuff bits, where W = 15, 17 or 21 for the latched mode.
- Any state -> IDLE on abort.

On start:
- crc_15 is always initialised to 0.
- With fd_iso = 1: crc_17 = 17'h10000 and crc_21 = 21'h100000.
- With fd_iso = 0: crc_17 = 0 and crc_21 = 0.
- The check counter and crc_ok are cleared.

Per-bit update in CALC, on each cycle with bit_valid:
- Feedback bit for each register: fb = bit_in ^ msb.
- Next value: reg = (reg << 1) ^ (fb ? POL : 0), truncated to the register width.
- CRC-15 skips bits with stuff_bit = 1, because Classical CAN excludes stuff bits from its CRC.
- CRC-17 and CRC-21 include stuff bits, because CAN FD includes dynamic stuff bits in its CRC.

Check phase, in CHECK with bit_valid:
- Bits with stuff_bit = 1 (FD fixed stuff bits) are ignored by all registers and do not advance the counter.
- All other bits are fed only into the selected register, using the same update rule, and advance a 5-bit counter.
- When the counter reaches W, the selected register is compared with zero, crc_ok takes the result, and crc_valid pulses.

Boundary cases:
- A bit_valid arriving together with calc_end is processed as a CALC bit.
- bit_valid in IDLE is ignored.
- start while busy restarts the frame.
- abort takes priority over start and bit_valid in the same cycle.
- crc_valid never asserts after an abort.

## Timing
- All registers clear to 0 on reset: crc_*, busy, crc_valid, crc_ok, stuff_cnt and stuff_par all read 0.
- CRC outputs are registered and reflect a bit one cycle after its bit_valid.
- start takes effect at the next clock edge; busy is high from the following cycle.
- crc_valid is high for exactly one cycle, in the cycle after the W-th check bit is sampled.
- busy falls in that same cycle.
- Reset asserted mid-frame clears everything immediately, asynchronously.

## Configuration
Macro: CAN_CRC_STUFF_CNT_EN.
- Defined: a 3-bit binary counter counts bit_valid & stuff_bit bits in CALC, wrapping mod 8. It clears on start and on abort.
  - stuff_cnt is the Gray code of the counter: 0..7 map to 000, 001, 011, 010, 110, 111, 101, 100.
  - stuff_par is the XOR of the three stuff_cnt bits.
  - Both outputs are registered and hold their value through CHECK.
- Undefined: the counter is not compiled in, and stuff_cnt and stuff_par are tied to 0.

## Structure
- A shared package can_crc_pkg holds:
  - typedef crc_mode_e: CRC15, CRC17, CRC21;
  - typedef crc_state_e;
  - localparams for the widths 15, 17 and 21;
  - the function gray3().
- One sub-module, can_crc_lfsr, is a single register parametrised by width, polynomial and stuff-skip, with inputs for init value, enable and bit. It is instantiated three times.

## Test plan
- Reset value: hold rst = 0 -> every output reads 0.
- Classic single bit: start with mode 0 and fd_iso 0, then one bit 1 -> crc_15 = 15'h4599, crc_17 = 17'h1685B, crc_21 = 21'h102899.
- ISO init: start with mode 2 and fd_iso 1, then one bit 0 -> crc_21 = 21'h102899 and crc_17 = 17'h1685B.
- Stuff skip: in mode 0, a bit 1 with stuff_bit = 1 -> crc_15 stays 0, while crc_17 and crc_21 update.
- Good and bad check: feed a data field, then its computed CRC, with one fixed stuff bit inserted -> crc_valid pulses once and crc_ok = 1. Flip one CRC bit -> crc_ok = 0.
- Abort and stuff count: inject 9 stuff bits, then abort during CHECK.
  - Before the abort, stuff_cnt = 001 and stuff_par = 1 with the macro defined, or 0 without it.
  - After the abort: busy = 0, no crc_valid pulse, and the FSM is in IDLE.
